lut_function_unit: RTL and testbench
====================================

Name: lut_function_unit

Overview:
- Programmable N_IN-input, N_OUT-output Boolean function unit; replaces fixed gate-level SOP/POS expression blocks with a runtime-loadable truth table.
- Registered evaluation path with valid/ready handshake, single-bit configuration write port, and a sweep mode.
- Sweep mode walks all 2^N_IN minterms of one output and reports its minterm count.
- Sits between input switch/decoder logic and downstream consumers in lab datapaths.

Parameters:
- N_IN, 4, number of function inputs (2..8); table depth 2^N_IN.
- N_OUT, 1, number of independent output functions (1..8).
- DEFAULT_TT, 16'h8F23, reset truth table replicated into every output (minterms 0,1,5,8,9,10,11,15); width 2^N_IN, LSB = minterm 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  $clog2(N_OUT) min 1  output function selected for write.
- cfg_addr  in  N_IN  minterm index to write.
- cfg_data  in  1  new table bit.
- cfg_err  out  1  one-cycle pulse: write rejected.
- in_valid  in  1  input vector valid.
- in_ready  out  1  unit accepts input.
- in_vec  in  N_IN  input vector; bit N_IN-1 = MSB variable (A).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_vec  out  N_OUT  function results; bit k = output k.
- sweep_start  in  1  request minterm count.
- sweep_sel  in  $clog2(N_OUT) min 1  output to sweep; sampled on start.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at sweep completion.
- sweep_count  out  N_IN+1  minterm count of last sweep.

Behaviour:
- Reset (async assert, sync release): table[k] = DEFAULT_TT for all k; out_valid=0, out_vec=0, cfg_err=0, sweep_busy=0, sweep_done=0, sweep_count=0, FSM=S_IDLE. Reset mid-sweep aborts the sweep, with no done pulse.
- Eval: in_ready = (state==S_IDLE) && (!out_valid || out_ready). On in_valid&&in_ready, out_vec[k] <= table[k][in_vec] and out_valid <= 1 next cycle. Latency 1 cycle, throughput 1 per cycle under continuous out_ready.
- out_valid clears when out_ready is high and no new accept occurs. out_vec is held stable while out_valid && !out_ready.
- Config: write applied at clock edge when cfg_we && state==S_IDLE. Same-cycle eval of the same address uses the OLD bit (read-before-write).
- cfg_sel >= N_OUT, or cfg_we during S_SWEEP/S_DONE: write dropped, cfg_err pulses 1 cycle.
- FSM states:
  - S_IDLE: on sweep_start && !out_valid → S_SWEEP; idx=0, acc=0, latch sweep_sel. If out_valid is pending, start is ignored (not queued). If sweep_sel >= N_OUT, start is ignored.
  - S_SWEEP: sweep_busy=1; each cycle acc += table[sel][idx], idx++. After idx = 2^N_IN-1 is processed → S_DONE. Duration is exactly 2^N_IN cycles.
  - S_DONE: sweep_count <= final acc, sweep_done=1 for this one cycle, → S_IDLE.
- sweep_count holds until the next completed sweep.
- sweep_start during S_SWEEP/S_DONE is ignored.
- in_valid is stalled (in_ready=0) throughout S_SWEEP/S_DONE.
- Width rules: idx is N_IN+1 bits so wrap is detected, not aliased. acc is N_IN+1 bits, so the all-ones table gives 2^N_IN without overflow.

Decomposition:
- Package lut_pkg: state enum {S_IDLE,S_SWEEP,S_DONE}, width helper SEL_W = (N_OUT>1)?$clog2(N_OUT):1, DEFAULT_TT constant.
- Sub-module lut_table: N_OUT x 2^N_IN bit storage with one async-read eval port, one async-read sweep port, one sync write port, and async reset to DEFAULT_TT.
- Top holds the handshake register, FSM, and counters.

Test Plan:
- Reset table, N_IN=4: apply in_vec 0..15 with out_ready=1 → out_vec[0] = 1,1,0,0,0,1,0,0,1,1,1,1,0,0,0,1; one result per cycle after 1-cycle latency.
- Backpressure: out_ready=0 with in_vec=5 then in_vec=2 → out_vec=1 held, in_ready=0, second vector not accepted. Raise out_ready → out_vec becomes 0 on the following cycle.
- Sweep after reset → sweep_busy high exactly 16 cycles, sweep_done pulse, sweep_count=8. Write cfg_addr=15, data=0, then sweep again → count=7.
- Write during sweep (cfg_addr=2, data=1) → cfg_err pulse, table unchanged, count still 7. Write cfg_sel=N_OUT in idle → cfg_err pulse.
- Same-cycle write addr=0 data=0 plus eval in_vec=0 → out_vec=1 (old value). Next eval in_vec=0 → 0.
- Deassert rst_n at sweep cycle 6 → all outputs zero immediately, no sweep_done. After release, table equals 16'h8F23 and in_vec=15 evaluates to 1.

Source files
------------

// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and constants for the programmable LUT function unit
package lut_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } lut_state_e;

    // Minterms 0,1,5,8,9,10,11,15 of a 4-input function; bit 0 is minterm 0.
    localparam logic [15:0] DEFAULT_TT = 16'h8F23;

    function automatic int sel_w(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/lut_table.sv
// rtl/lut_table.sv - N_OUT x 2^N_IN truth-table storage, two async read ports, one sync write port
module lut_table #(
    parameter int                      N_IN       = 4,
    parameter int                      N_OUT      = 1,
    parameter int                      SEL_W      = 1,
    parameter logic [(1 << N_IN)-1:0]  DEFAULT_TT = lut_pkg::DEFAULT_TT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [SEL_W-1:0] wsel_i,
    input  logic [N_IN-1:0]  waddr_i,
    input  logic             wdata_i,
    input  logic [N_IN-1:0]  eval_addr_i,
    output logic [N_OUT-1:0] eval_o,
    input  logic [SEL_W-1:0] sweep_sel_i,
    input  logic [N_IN-1:0]  sweep_addr_i,
    output logic             sweep_bit_o
);

    localparam int DEPTH = 1 << N_IN;

    logic [N_OUT-1:0][DEPTH-1:0] tbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                tbl_q[k] <= DEFAULT_TT;
            end
        end else if (we_i) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (wsel_i == SEL_W'(k)) begin
                    tbl_q[k][waddr_i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        eval_o = '0;
        for (int k = 0; k < N_OUT; k++) begin
            eval_o[k] = tbl_q[k][eval_addr_i];
        end
    end

    // Out-of-range selects read as 0; the top never starts a sweep on one.
    always_comb begin
        sweep_bit_o = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sweep_sel_i == SEL_W'(k)) begin
                sweep_bit_o = tbl_q[k][sweep_addr_i];
            end
        end
    end

endmodule

// File: rtl/lut_function_unit.sv
// rtl/lut_function_unit.sv - runtime-loadable Boolean function unit with eval handshake and minterm sweep
module lut_function_unit #(
    parameter int                      N_IN       = 4,
    parameter int                      N_OUT      = 1,
    parameter logic [(1 << N_IN)-1:0]  DEFAULT_TT = lut_pkg::DEFAULT_TT,
    localparam int                     SEL_W      = lut_pkg::sel_w(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we_i,
    input  logic [SEL_W-1:0] cfg_sel_i,
    input  logic [N_IN-1:0]  cfg_addr_i,
    input  logic             cfg_data_i,
    output logic             cfg_err_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N_IN-1:0]  in_vec_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N_OUT-1:0] out_vec_o,
    input  logic             sweep_start_i,
    input  logic [SEL_W-1:0] sweep_sel_i,
    output logic             sweep_busy_o,
    output logic             sweep_done_o,
    output logic [N_IN:0]    sweep_count_o
);

    import lut_pkg::*;

    localparam int             DEPTH   = 1 << N_IN;
    // One extra bit so N_OUT itself is representable when N_OUT is a power of two.
    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);
    localparam logic [N_IN:0]  IDX_LAST = (N_IN + 1)'(DEPTH - 1);

    lut_state_e       state_q;
    logic [N_IN:0]    idx_q;
    logic [N_IN:0]    acc_q;
    logic [N_IN:0]    acc_d;
    logic [SEL_W-1:0] sel_q;
    logic             out_valid_q;
    logic [N_OUT-1:0] out_vec_q;
    logic             cfg_err_q;
    logic             sweep_busy_q;
    logic             sweep_done_q;
    logic [N_IN:0]    sweep_count_q;

    logic             idle;
    logic             accept;
    logic             cfg_wr_ok;
    logic             start_ok;
    logic [N_OUT-1:0] eval_bits;
    logic             sweep_bit;

    assign idle       = (state_q == S_IDLE);
    assign in_ready_o = idle && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign cfg_wr_ok  = cfg_we_i && idle && ({1'b0, cfg_sel_i} < N_OUT_W);
    assign start_ok   = idle && sweep_start_i && !out_valid_q && ({1'b0, sweep_sel_i} < N_OUT_W);
    assign acc_d      = acc_q + {{N_IN{1'b0}}, sweep_bit};

    lut_table #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .SEL_W      (SEL_W),
        .DEFAULT_TT (DEFAULT_TT)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         (cfg_wr_ok),
        .wsel_i       (cfg_sel_i),
        .waddr_i      (cfg_addr_i),
        .wdata_i      (cfg_data_i),
        .eval_addr_i  (in_vec_i),
        .eval_o       (eval_bits),
        .sweep_sel_i  (sel_q),
        .sweep_addr_i (idx_q[N_IN-1:0]),
        .sweep_bit_o  (sweep_bit)
    );

    // Result register: eval reads the table before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i && !cfg_wr_ok;
            if (accept) begin
                out_vec_q   <= eval_bits;
                out_valid_q <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            sel_q         <= '0;
            sweep_busy_q  <= 1'b0;
            sweep_done_q  <= 1'b0;
            sweep_count_q <= '0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q      <= S_SWEEP;
                        idx_q        <= '0;
                        acc_q        <= '0;
                        sel_q        <= sweep_sel_i;
                        sweep_busy_q <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_q       <= S_DONE;
                        sweep_busy_q  <= 1'b0;
                        sweep_done_q  <= 1'b1;
                        sweep_count_q <= acc_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_vec_o     = out_vec_q;
    assign cfg_err_o     = cfg_err_q;
    assign sweep_busy_o  = sweep_busy_q;
    assign sweep_done_o  = sweep_done_q;
    assign sweep_count_o = sweep_count_q;

endmodule

// File: tb/tb_lut_function_unit.sv
// tb/tb_lut_function_unit.sv - directed bench with a truth-table reference model for lut_function_unit
module tb_lut_function_unit;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic [N_IN-1:0]  cfg_addr = '0;
    logic             cfg_data = 1'b0;
    logic             cfg_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N_OUT-1:0] out_vec;
    logic             sweep_start = 1'b0;
    logic [SEL_W-1:0] sweep_sel = '0;
    logic             sweep_busy;
    logic             sweep_done;
    logic [N_IN:0]    sweep_count;

    always #5 clk = ~clk;

    lut_function_unit #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we_i      (cfg_we),
        .cfg_sel_i     (cfg_sel),
        .cfg_addr_i    (cfg_addr),
        .cfg_data_i    (cfg_data),
        .cfg_err_o     (cfg_err),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_vec_i      (in_vec),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_vec_o     (out_vec),
        .sweep_start_i (sweep_start),
        .sweep_sel_i   (sweep_sel),
        .sweep_busy_o  (sweep_busy),
        .sweep_done_o  (sweep_done),
        .sweep_count_o (sweep_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole truth tables, a sweep countdown and a popcount.
    logic [15:0]      m_tt [N_OUT];
    logic             m_ov;
    logic [N_OUT-1:0] m_ovec;
    logic             m_err;
    logic             m_done;
    int               m_busy_left;
    logic [4:0]       m_count;
    logic [4:0]       m_pending;
    logic             m_idle;
    logic             m_rdy;
    logic             m_ov_before;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) m_tt[k] = 16'h8F23;
            m_ov = 1'b0;
            m_ovec = '0;
            m_err = 1'b0;
            m_done = 1'b0;
            m_busy_left = 0;
            m_count = '0;
            m_pending = '0;
        end else begin
            m_idle = (m_busy_left == 0) && !m_done;
            m_rdy = m_idle && (!m_ov || out_ready);
            m_ov_before = m_ov;
            if (in_valid && m_rdy) begin
                for (int k = 0; k < N_OUT; k++) m_ovec[k] = m_tt[k][in_vec];
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_err = cfg_we && !(m_idle && (int'(cfg_sel) < N_OUT));
            if (cfg_we && m_idle && (int'(cfg_sel) < N_OUT)) m_tt[cfg_sel][cfg_addr] = cfg_data;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_done = 1'b1;
                    m_count = m_pending;
                end
            end else if (sweep_start && !m_ov_before && (int'(sweep_sel) < N_OUT)) begin
                m_busy_left = 16;
                m_pending = 5'($countones(m_tt[sweep_sel]));
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (m_busy_left == 0 && !m_done) && (!m_ov || out_ready));
        chk("out_valid", out_valid, m_ov);
        chk("out_vec", out_vec, m_ovec);
        chk("cfg_err", cfg_err, m_err);
        chk("sweep_busy", sweep_busy, m_busy_left > 0);
        chk("sweep_done", sweep_done, m_done);
        chk("sweep_count", sweep_count, m_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int busy_n, output bit seen, output logic [4:0] cnt);
        busy_n = 0;
        seen = 1'b0;
        cnt = '0;
        for (int c = 0; c < 40; c++) begin
            if (sweep_busy) busy_n++;
            if (sweep_done) begin
                seen = 1'b1;
                cnt = sweep_count;
                break;
            end
            tick();
        end
    endtask

    task automatic run_sweep(input logic [SEL_W-1:0] sel, input int exp_cnt);
        int busy_n;
        bit seen;
        logic [4:0] cnt;
        sweep_sel = sel;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        wait_done(busy_n, seen, cnt);
        chk("sweep_busy_cycles", busy_n, 16);
        chk("sweep_done_seen", seen, 1);
        chk("sweep_count_lit", cnt, exp_cnt);
        tick();
    endtask

    int lit [16] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        int busy_n;
        bit seen;
        logic [4:0] cnt;
        int dn;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sweep_count", sweep_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sweep_busy", sweep_busy, 0);

        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_vec = 4'(i);
            tick();
            chk("eval_default", out_vec[0], lit[i]);
            chk("eval_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("eval_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 4'd5;
        tick();
        chk("bp_first", out_vec, 3'b111);
        in_vec = 4'd2;
        chk("bp_ready_low", in_ready, 0);
        tick();
        chk("bp_held", out_vec, 3'b111);
        chk("bp_held_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_second", out_vec, 3'b000);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 4'd0;
        tick();
        in_valid = 1'b0;
        sweep_sel = 2'd0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("start_blocked_pending", sweep_busy, 0);
        out_ready = 1'b1;
        tick();

        run_sweep(2'd0, 8);

        cfg_we = 1'b1;
        cfg_sel = 2'd0;
        cfg_addr = 4'd15;
        cfg_data = 1'b0;
        tick();
        cfg_we = 1'b0;
        chk("cfg_ok_no_err", cfg_err, 0);
        run_sweep(2'd0, 7);

        sweep_sel = 2'd0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 4'd2;
        cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("cfg_err_sweep", cfg_err, 1);
        wait_done(busy_n, seen, cnt);
        chk("sweep_done_after_err", seen, 1);
        chk("count_unchanged", cnt, 7);
        tick();

        cfg_we = 1'b1;
        cfg_sel = 2'd3;
        tick();
        cfg_we = 1'b0;
        chk("cfg_err_bad_sel", cfg_err, 1);
        tick();
        chk("cfg_err_one_cycle", cfg_err, 0);

        cfg_we = 1'b1;
        cfg_sel = 2'd1;
        cfg_addr = 4'd3;
        cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b1;
        in_vec = 4'd3;
        tick();
        in_valid = 1'b0;
        chk("eval_sel1_only", out_vec, 3'b010);
        tick();
        run_sweep(2'd1, 9);
        run_sweep(2'd2, 8);

        sweep_sel = 2'd3;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("start_bad_sel", sweep_busy, 0);

        cfg_we = 1'b1;
        cfg_sel = 2'd0;
        cfg_addr = 4'd0;
        cfg_data = 1'b0;
        in_valid = 1'b1;
        in_vec = 4'd0;
        tick();
        cfg_we = 1'b0;
        chk("rbw_old", out_vec[0], 1);
        tick();
        chk("rbw_new", out_vec[0], 0);
        in_valid = 1'b0;
        tick();

        sweep_sel = 2'd0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (5) tick();
        chk("busy_cycle6", sweep_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", sweep_busy, 0);
        chk("rst_mid_done", sweep_done, 0);
        chk("rst_mid_count", sweep_count, 0);
        chk("rst_mid_valid", out_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sweep_done) dn++;
        end
        chk("no_done_after_abort", dn, 0);

        in_valid = 1'b1;
        in_vec = 4'd15;
        tick();
        chk("restored_m15", out_vec, 3'b111);
        in_vec = 4'd0;
        tick();
        chk("restored_m0", out_vec, 3'b111);
        in_valid = 1'b0;
        tick();
        run_sweep(2'd0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
